// File: rtl/mem_bus_arbiter.sv
// Two-master SRAM-bus arbiter: data access has priority over instruction fetch,
// with a bounded data streak so a pending fetch is eventually granted.
module mem_bus_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam logic [3:0] BURST = 4'(DATA_BURST_MAX);

  state_t     state;
  logic       owner;
  logic [3:0] streak;

  logic grant_data;
  logic addr_hs;
  logic data_hs;

  // A pending fetch overrides data once the streak limit is reached.
  assign grant_data = data_req && !(inst_req && (streak >= BURST));

  assign addr_hs = (state == ADDR) && bus_addr_ok;
  assign data_hs = (addr_hs && bus_data_ok)
                || ((state == DATA) && bus_data_ok);

  assign inst_addr_ok = addr_hs && !owner;
  assign data_addr_ok = addr_hs && owner;
  assign inst_data_ok = data_hs && !owner;
  assign data_data_ok = data_hs && owner;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      streak    <= 4'd0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'b00;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= 1'b1;
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_size  <= data_size;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            state     <= ADDR;
            if (!inst_req)
              streak <= 4'd0;
            else if (streak != 4'hF)
              streak <= streak + 4'd1;
          end else if (inst_req) begin
            owner     <= 1'b0;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_size  <= 2'b10;
            bus_addr  <= inst_addr;
            bus_wdata <= 32'd0;
            streak    <= 4'd0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= bus_data_ok ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bus_data_ok)
            state <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: load, store, fetch,
// contention order and asynchronous reset mid-transaction.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] oks;
  assign oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_BURST_MAX(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int         ngrant;
    logic [9:0] order;

    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = '0;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_wr", 32'(bus_wr), 32'd0);
    chk("rst_size", 32'(bus_size), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_oks", 32'(oks), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // single load
    @(negedge clk);
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'b10;
    data_addr = 32'h8000_0010;
    #1;
    chk("ld_idle_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    #1;
    chk("ld_c1_req", 32'(bus_req), 32'd1);
    chk("ld_c1_addr", bus_addr, 32'h8000_0010);
    chk("ld_c1_size", 32'(bus_size), 32'd2);
    chk("ld_c1_oks", 32'(oks), 32'd0);
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    chk("ld_aok_req", 32'(bus_req), 32'd1);
    chk("ld_aok_oks", 32'(oks), 32'b0010);
    @(negedge clk);
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    #1;
    chk("ld_d1_req", 32'(bus_req), 32'd0);
    chk("ld_d1_oks", 32'(oks), 32'd0);
    @(negedge clk);
    #1;
    chk("ld_d2_oks", 32'(oks), 32'd0);
    @(negedge clk);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h1234_5678;
    #1;
    chk("ld_dok_oks", 32'(oks), 32'b0001);
    chk("ld_rdata", data_rdata, 32'h1234_5678);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    chk("ld_end_oks", 32'(oks), 32'd0);
    chk("ld_end_req", 32'(bus_req), 32'd0);

    // store byte, then same-cycle addr_ok + data_ok
    @(negedge clk);
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'b00;
    data_addr  = 32'hBFC0_0003;
    data_wdata = 32'hABAB_ABAB;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("st_req", 32'(bus_req), 32'd1);
      chk("st_wr", 32'(bus_wr), 32'd1);
      chk("st_size", 32'(bus_size), 32'd0);
      chk("st_addr", bus_addr, 32'hBFC0_0003);
      chk("st_wdata", bus_wdata, 32'hABAB_ABAB);
    end
    @(negedge clk);
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    chk("st_both_oks", 32'(oks), 32'b0011);

    // fetch only, issued during the idle bubble
    @(negedge clk);
    data_req    = 1'b0;
    data_wr     = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'hBFC0_0000;
    #1;
    chk("bubble_req", 32'(bus_req), 32'd0);
    chk("bubble_oks", 32'(oks), 32'd0);
    @(negedge clk);
    #1;
    chk("if_req", 32'(bus_req), 32'd1);
    chk("if_wr", 32'(bus_wr), 32'd0);
    chk("if_size", 32'(bus_size), 32'd2);
    chk("if_addr", bus_addr, 32'hBFC0_0000);
    chk("if_wdata", bus_wdata, 32'd0);
    bus_addr_ok = 1'b1;
    #1;
    chk("if_aok_oks", 32'(oks), 32'b1000);
    @(negedge clk);
    inst_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hCAFE_F00D;
    #1;
    chk("if_dok_oks", 32'(oks), 32'b0100);
    chk("if_rdata", inst_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    bus_data_ok = 1'b0;

    // contention: both held, bus answers at once
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_1000;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'b10;
    data_addr  = 32'h0000_2000;
    ngrant     = 0;
    order      = '0;
    for (int c = 0; c < 60 && ngrant < 10; c++) begin
      @(negedge clk);
      bus_addr_ok = bus_req;
      bus_data_ok = bus_req;
      #1;
      if (inst_addr_ok || data_addr_ok) begin
        order  = {order[8:0], data_addr_ok};
        ngrant++;
        if (inst_addr_ok && data_addr_ok)
          chk("ct_dual", 32'd1, 32'd0);
      end
    end
    chk("ct_count", 32'(ngrant), 32'd10);
    chk("ct_order", 32'(order), 32'h3DE);
    @(negedge clk);
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    @(negedge clk);
    #1;
    chk("ct_quiet", 32'(bus_req), 32'd0);

    // reset while waiting in the data phase
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h0000_3000;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    chk("rs_aok_oks", 32'(oks), 32'b0010);
    @(negedge clk);
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_async_req", 32'(bus_req), 32'd0);
    chk("rs_async_addr", bus_addr, 32'd0);
    @(negedge clk);
    resetn      = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    chk("rs_stray_oks", 32'(oks), 32'd0);
    @(negedge clk);
    bus_data_ok = 1'b0;
    data_req    = 1'b1;
    data_addr   = 32'h0000_4004;
    @(negedge clk);
    #1;
    chk("rs_new_req", 32'(bus_req), 32'd1);
    chk("rs_new_addr", bus_addr, 32'h0000_4004);
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    chk("rs_new_oks", 32'(oks), 32'b0011);
    @(negedge clk);
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the CPU's single SRAM-like memory bus between instruction fetch (IF stage) and data access (MEM stage, downstream of byte-select and alignment logic). It grants one requester at a time and sequences that request through the bus address phase and data phase. It forwards the handshakes back to the winning master. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.

## Interface
- `DATA_BURST_MAX`, default 4: maximum consecutive data grants while an instruction request is pending (range 1–15).
- `clk` input 1: clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_req` input 1: fetch request; held with its fields until `inst_addr_ok`.
- `inst_addr` input 32: fetch address; always a word read, size 2'b10.
- `inst_addr_ok` output 1: fetch address accepted by the bus.
- `inst_data_ok` output 1: fetch data valid on `inst_rdata`.
- `inst_rdata` output 32: fetch read data.
- `data_req` input 1: data request; held stable until `data_addr_ok`.
- `data_wr` input 1: 1 = store, 0 = load.
- `data_size` input 2: 00 = byte, 01 = half, 10 = word.
- `data_addr` input 32: byte address.
- `data_wdata` input 32: store data, already lane-replicated.
- `data_addr_ok` output 1: data address accepted.
- `data_data_ok` output 1: load data valid, or store completed.
- `data_rdata` output 32: load data, raw word.
- `bus_req`, `bus_wr`, `bus_size[1:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]` outputs: downstream request.
- `bus_addr_ok` input 1 and `bus_data_ok` input 1: downstream handshakes.
- `bus_rdata` input 32: downstream read data.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`. Register `owner`: 0 = inst, 1 = data. Register `streak`: 4-bit count of consecutive data grants.
- **IDLE**
  - If any request is present, grant one, latch its fields into the bus registers, set `owner`, and go to `ADDR`.
  - Grant rule: data wins unless `inst_req`=1 and `streak` ≥ `DATA_BURST_MAX`; in that case inst wins.
  - On a data grant, `streak` increments, saturating at 15. On an inst grant, `streak` clears.
  - If `inst_req`=0 on a data grant, `streak` clears instead.
- **ADDR**
  - `bus_req`=1 and bus fields come from registers; they are stable for the whole state.
  - On `bus_addr_ok`: pulse `owner`'s `*_addr_ok` in the same cycle (combinational) and go to `DATA`.
  - If `bus_data_ok` is also high in that cycle, the transaction completes: pulse `*_data_ok` too and go to `IDLE`.
- **DATA**
  - `bus_req`=0.
  - On `bus_data_ok`: pulse `owner`'s `*_data_ok` (combinational) and go to `IDLE`.
- An inst grant drives `bus_wr`=0, `bus_size`=2'b10, `bus_wdata`=0.
- `inst_rdata` and `data_rdata` are both wired to `bus_rdata`. Only the `*_data_ok` signals qualify them.
- `*_addr_ok` and `*_data_ok` are never asserted for the non-owner, and never in `IDLE`.
- `bus_data_ok` in `IDLE` is ignored.
- A requester that drops its `req` before `addr_ok` after being latched does not cancel the bus transaction. It still receives both handshakes.
- Only one transaction is outstanding; no request pipelining.

## Timing
- **Reset** (asynchronous, immediate on `resetn`=0):
  - state = `IDLE`, `owner`=0, `streak`=0.
  - `bus_req`=0, `bus_wr`=0, `bus_size`=0, `bus_addr`=0, `bus_wdata`=0.
  - All `*_addr_ok`/`*_data_ok` outputs = 0.
  - A transaction in progress is abandoned; the bus slave shares `resetn`.
- **Grant latency:** a request seen in `IDLE` at edge N gives `bus_req`=1 from cycle N+1.
- **Minimum transaction:** 2 cycles (`IDLE`→`ADDR` with `addr_ok`+`data_ok` together). Then 1 `IDLE` bubble before the next grant.
- **Back-to-back throughput:** 1 transaction per 3 cycles when the bus answers `addr_ok` and `data_ok` in consecutive cycles.
- **Handshake pulses:** `*_addr_ok` and `*_data_ok` are one cycle wide, coincident with the bus inputs. They have zero added latency.
- **Simultaneous `inst_req` and `data_req` in `IDLE`:** grant follows the `streak` rule above. The loser is held and is not acknowledged.

## Test plan
- **Single load:**
  - Stimulus: `data_req`=1, `wr`=0, `size`=10, `addr`=0x8000_0010; bus gives `addr_ok` at 2 cycles and `data_ok` +3 cycles later with `bus_rdata`=0x1234_5678.
  - Response: `bus_req` high exactly from cycle 1 until `addr_ok`; `data_addr_ok` 1 pulse; `data_data_ok` 1 pulse with `data_rdata`=0x1234_5678; no `inst_*_ok` pulses.
- **Store byte:**
  - Stimulus: `wr`=1, `size`=00, `addr`=0xBFC0_0003, `wdata`=0xABABABAB.
  - Response: bus fields match for the whole `ADDR` phase; one `data_data_ok`.
- **Contention:** `inst_req` and `data_req` held high continuously, `DATA_BURST_MAX`=4, bus answering immediately → grant order D, D, D, D, I, D, D, D, D, I.
- **Fetch only:** `inst_req`=1, `addr`=0xBFC0_0000 → `bus_wr`=0, `bus_size`=10, `inst_data_ok` with the bus data; `streak` stays 0.
- **Same-cycle `addr_ok`+`data_ok`:** both owner pulses occur in one cycle, FSM returns to `IDLE`, next grant follows 1 cycle later.
- **Reset mid-`DATA`:** `resetn`=0 asynchronously while waiting for `data_ok` → `bus_req`=0 immediately; after release, a stray `bus_data_ok` produces no `*_data_ok`, and a new request is granted normally.
